// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong frame buffer that turns bit-reversed FFT words into natural-order words.
// Optional peak-bin tracker (peak_idx/peak_valid) is built when FFT_REORDER_PEAK_EN is defined.
module fft_out_reorder #(
  parameter int DW    = 13,
  parameter int LANES = 16,
  parameter int WORDS = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic [LANES*DW-1:0]             din_re_t,
  input  logic [LANES*DW-1:0]             din_im_t,
  output logic                            valid_out,
  output logic [LANES*DW-1:0]             dout_re_t,
  output logic [LANES*DW-1:0]             dout_im_t,
  output logic                            frame_first,
  output logic                            frame_last,
`ifdef FFT_REORDER_PEAK_EN
  output logic [$clog2(LANES*WORDS)-1:0]  peak_idx,
  output logic                            peak_valid,
`endif
  output logic                            overflow
);

  localparam int N  = LANES * WORDS;
  localparam int LB = $clog2(LANES);
  localparam int WB = $clog2(WORDS);

  function automatic logic [LB-1:0] rev_lane(input logic [LB-1:0] v);
    logic [LB-1:0] r;
    r = '0;
    for (int i = 0; i < LB; i++) r[i] = v[LB-1-i];
    return r;
  endfunction

  function automatic logic [WB-1:0] rev_word(input logic [WB-1:0] v);
    logic [WB-1:0] r;
    r = '0;
    for (int i = 0; i < WB; i++) r[i] = v[WB-1-i];
    return r;
  endfunction

  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nxt;

  logic [WB-1:0] wcnt, rcnt;
  logic          wbank, rbank;
  logic [1:0]    full;
  logic          bank_done, drop, commit, rd_last, ready_cur, ready_oth;

  logic [DW-1:0] mem_re [2*N];
  logic [DW-1:0] mem_im [2*N];

  assign bank_done = valid_in && (wcnt == WB'(WORDS - 1));
  assign rd_last   = (state == READ) && (rcnt == WB'(WORDS - 1));
  // The bank being drained this very edge counts as free, so back-to-back frames never overflow.
  assign drop      = bank_done && full[~wbank] && !(rd_last && (rbank != wbank));
  assign commit    = bank_done && !drop;
  assign ready_cur = full[rbank]  || (commit && (wbank == rbank));
  assign ready_oth = full[~rbank] || (commit && (wbank != rbank));

  // ---- write side: scatter each word to its natural-order bin address ----
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int l = 0; l < LANES; l++) begin
        mem_re[{wbank, rev_lane(LB'(l)), rev_word(wcnt)}] <= din_re_t[l*DW +: DW];
        mem_im[{wbank, rev_lane(LB'(l)), rev_word(wcnt)}] <= din_im_t[l*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      full     <= '0;
      overflow <= 1'b0;
    end else begin
      if (valid_in) wcnt <= wcnt + 1'b1;
      if (drop) overflow <= 1'b1;
      if (rd_last) full[rbank] <= 1'b0;
      if (commit) begin
        full[wbank] <= 1'b1;
        wbank       <= ~wbank;
      end
    end
  end

  // ---- read FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == READ) begin
        rcnt <= rcnt + 1'b1;
        if (rd_last) rbank <= ~rbank;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready_cur) state_nxt = READ;
      READ:    if (rd_last && !ready_oth) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- p0: gather 16 consecutive bins of the read bank ----
  logic [LANES*DW-1:0] rd_re_p0, rd_im_p0;

  always_comb begin
    rd_re_p0 = '0;
    rd_im_p0 = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_re_p0[l*DW +: DW] = mem_re[{rbank, rcnt, LB'(l)}];
      rd_im_p0[l*DW +: DW] = mem_im[{rbank, rcnt, LB'(l)}];
    end
  end

  // ---- p1: registered outputs, forced to zero outside a frame ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
      dout_re_t   <= '0;
      dout_im_t   <= '0;
    end else if (state == READ) begin
      valid_out   <= 1'b1;
      frame_first <= (rcnt == '0);
      frame_last  <= rd_last;
      dout_re_t   <= rd_re_p0;
      dout_im_t   <= rd_im_p0;
    end else begin
      valid_out   <= 1'b0;
      frame_first <= 1'b0;
      frame_last  <= 1'b0;
      dout_re_t   <= '0;
      dout_im_t   <= '0;
    end
  end

`ifdef FFT_REORDER_PEAK_EN
  localparam int KB = LB + WB;
  localparam int MW = DW + 2;

  function automatic logic [MW-1:0] mag(input logic signed [DW-1:0] re,
                                        input logic signed [DW-1:0] im);
    logic [DW-1:0] ar, ai;
    ar = re[DW-1] ? -re : re;
    ai = im[DW-1] ? -im : im;
    return MW'(ar) + MW'(ai);
  endfunction

  logic [MW-1:0] wmax_p0, best_mag_p1;
  logic [LB-1:0] wlane_p0;
  logic [KB-1:0] best_idx_p1;

  // Strict compare keeps the lowest lane on ties within a word.
  always_comb begin
    wmax_p0  = mag(rd_re_p0[DW-1:0], rd_im_p0[DW-1:0]);
    wlane_p0 = '0;
    for (int l = 1; l < LANES; l++) begin
      if (mag(rd_re_p0[l*DW +: DW], rd_im_p0[l*DW +: DW]) > wmax_p0) begin
        wmax_p0  = mag(rd_re_p0[l*DW +: DW], rd_im_p0[l*DW +: DW]);
        wlane_p0 = LB'(l);
      end
    end
  end

  // ---- p1: running frame maximum; earlier words win ties ----
  always_ff @(posedge clk) begin
    if ((state == READ) && ((rcnt == '0) || (wmax_p0 > best_mag_p1))) begin
      best_mag_p1 <= wmax_p0;
      best_idx_p1 <= {rcnt, wlane_p0};
    end
  end

  // ---- p2: report one cycle after frame_last ----
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid <= 1'b0;
      peak_idx   <= '0;
    end else begin
      peak_valid <= frame_last;
      if (frame_last) peak_idx <= best_idx_p1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: bin-level reference model plus literal spot checks.
module tb_fft_out_reorder;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [207:0] din_re_t, din_im_t;
  logic         valid_out;
  logic [207:0] dout_re_t, dout_im_t;
  logic         frame_first, frame_last, overflow;
`ifdef FFT_REORDER_PEAK_EN
  logic [8:0]   peak_idx;
  logic         peak_valid;
`endif

  always #5 clk = ~clk;

  fft_out_reorder dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .din_re_t(din_re_t), .din_im_t(din_im_t),
    .valid_out(valid_out), .dout_re_t(dout_re_t), .dout_im_t(dout_im_t),
    .frame_first(frame_first), .frame_last(frame_last),
`ifdef FFT_REORDER_PEAK_EN
    .peak_idx(peak_idx), .peak_valid(peak_valid),
`endif
    .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [207:0] act, input logic [207:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lane(input logic [207:0] v, input int l);
    logic signed [12:0] s;
    s = v[l*13 +: 13];
    return int'(s);
  endfunction

  // Natural bin carried by input word c, lane l: high 4 bits rev(l), low 5 bits rev(c).
  function automatic int bin_of(input int c, input int l);
    int rc, rl;
    rc = 0;
    rl = 0;
    for (int i = 0; i < 5; i++) rc = rc * 2 + ((c >> i) & 1);
    for (int i = 0; i < 4; i++) rl = rl * 2 + ((l >> i) & 1);
    return rl * 32 + rc;
  endfunction

  function automatic int absval(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // ---------------- reference model and per-cycle compare ----------------
  int e = 0;
  int mdl_cnt = 0;
  int mdl_re[512], mdl_im[512];
  int exp_re[$], exp_im[$];
  int sched[$];
  int pk_when[$], pk_idx[$];
  int next_free = 0;
  int done_edge = 0;
  int vo_run = 0, vo_max = 0;
  int m_k, m_start, m_bm, m_bi, m_mag, m_idx, m_t;
  bit exp_v;
  logic [207:0] w_re, w_im;

  always @(posedge clk) begin
    e++;
    if (rst) begin
      mdl_cnt = 0;
      exp_re.delete();
      exp_im.delete();
      sched.delete();
      pk_when.delete();
      pk_idx.delete();
      next_free = 0;
    end else if (valid_in) begin
      for (int l = 0; l < 16; l++) begin
        m_k = bin_of(mdl_cnt, l);
        mdl_re[m_k] = lane(din_re_t, l);
        mdl_im[m_k] = lane(din_im_t, l);
      end
      mdl_cnt++;
      if (mdl_cnt == 32) begin
        mdl_cnt = 0;
        m_bm = -1;
        m_bi = 0;
        for (int k = 0; k < 512; k++) begin
          exp_re.push_back(mdl_re[k]);
          exp_im.push_back(mdl_im[k]);
          m_mag = absval(mdl_re[k]) + absval(mdl_im[k]);
          if (m_mag > m_bm) begin
            m_bm = m_mag;
            m_bi = k;
          end
        end
        m_start = (e + 1 > next_free) ? e + 1 : next_free;
        sched.push_back(m_start);
        next_free = m_start + 32;
        done_edge = e;
        pk_when.push_back(m_start + 32);
        pk_idx.push_back(m_bi);
      end
    end
    #1;
    exp_v = (sched.size() > 0) && (e >= sched[0]);
    chk_int("valid_out", int'(valid_out), int'(exp_v));
    if (exp_v) begin
      m_idx = e - sched[0];
      for (int l = 0; l < 16; l++) begin
        m_t = exp_re.pop_front();
        w_re[l*13 +: 13] = m_t[12:0];
        m_t = exp_im.pop_front();
        w_im[l*13 +: 13] = m_t[12:0];
      end
      chk_vec("dout_re", dout_re_t, w_re);
      chk_vec("dout_im", dout_im_t, w_im);
      chk_int("frame_first", int'(frame_first), int'(m_idx == 0));
      chk_int("frame_last", int'(frame_last), int'(m_idx == 31));
      if (m_idx == 31) void'(sched.pop_front());
    end else begin
      chk_vec("dout_re_idle", dout_re_t, '0);
      chk_vec("dout_im_idle", dout_im_t, '0);
      chk_int("flags_idle", int'(frame_first) + int'(frame_last), 0);
    end
    chk_int("overflow", int'(overflow), 0);
`ifdef FFT_REORDER_PEAK_EN
    if (pk_when.size() > 0 && e == pk_when[0]) begin
      chk_int("peak_valid", int'(peak_valid), 1);
      chk_int("peak_idx", int'(peak_idx), pk_idx[0]);
      void'(pk_when.pop_front());
      void'(pk_idx.pop_front());
    end else begin
      chk_int("peak_valid_idle", int'(peak_valid), 0);
    end
`endif
    if (valid_out) vo_run++;
    else vo_run = 0;
    if (vo_run > vo_max) vo_max = vo_run;
  end

  // ---------------- stimulus ----------------
  int fr_re[512], fr_im[512];
  int seen_edge;

  task automatic rand_din();
    for (int l = 0; l < 16; l++) begin
      din_re_t[l*13 +: 13] = 13'($urandom());
      din_im_t[l*13 +: 13] = 13'($urandom());
    end
  endtask

  task automatic drive_word(input int c);
    int k, t;
    for (int l = 0; l < 16; l++) begin
      k = bin_of(c, l);
      t = fr_re[k];
      din_re_t[l*13 +: 13] = t[12:0];
      t = fr_im[k];
      din_im_t[l*13 +: 13] = t[12:0];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      rand_din();
    end
  endtask

  // gap_mode: 0 contiguous, 1 alternate 1/0, 2 random gaps
  task automatic send_frame(input int gap_mode);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      valid_in = 1'b1;
      drive_word(c);
      if (gap_mode == 1) idle(1);
      else if (gap_mode == 2 && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 512; k++) begin
      fr_re[k] = k;
      fr_im[k] = -k;
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 512; k++) begin
      fr_re[k] = int'($urandom_range(0, 8191)) - 4096;
      fr_im[k] = int'($urandom_range(0, 8191)) - 4096;
    end
  endtask

  task automatic fill_zero();
    for (int k = 0; k < 512; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
  endtask

  task automatic wait_first(input string tag);
    int n;
    n = 0;
    while (!(valid_out && frame_first) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    seen_edge = e;
    chk_int({tag, "_first_seen"}, int'(valid_out && frame_first), 1);
  endtask

  task automatic next_word();
    @(posedge clk);
    #2;
  endtask

  task automatic check_ramp_out(input string tag);
    chk_int({tag, "_w0l1_re"}, lane(dout_re_t, 1), 1);
    chk_int({tag, "_w0l1_im"}, lane(dout_im_t, 1), -1);
    next_word();
    chk_int({tag, "_w1l0_re"}, lane(dout_re_t, 0), 16);
    chk_int({tag, "_w1l0_im"}, lane(dout_im_t, 0), -16);
    repeat (30) next_word();
    chk_int({tag, "_w31_last"}, int'(frame_last), 1);
    chk_int({tag, "_w31l15_re"}, lane(dout_re_t, 15), 511);
    chk_int({tag, "_w31l15_im"}, lane(dout_im_t, 15), -511);
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    din_re_t = '0;
    din_im_t = '0;
    repeat (3) @(negedge clk);
    chk_int("reset_valid", int'(valid_out), 0);
    chk_vec("reset_dout", dout_re_t | dout_im_t, '0);
    rst = 1'b0;

    // Ramp, contiguous
    fill_ramp();
    send_frame(0);
    idle(1);
    wait_first("ramp");
    chk_int("ramp_latency", seen_edge - done_edge, 1);
    check_ramp_out("ramp");
    idle(10);

    // Impulse at bin 300 = word 18 lane 12
    fill_zero();
    fr_re[300] = 4095;
    fr_im[300] = -4096;
    send_frame(0);
    idle(1);
    wait_first("imp");
    repeat (18) next_word();
    chk_int("imp_re", lane(dout_re_t, 12), 4095);
    chk_int("imp_im", lane(dout_im_t, 12), -4096);
    chk_int("imp_neighbour", lane(dout_re_t, 11), 0);
    idle(30);

    // Three back-to-back random frames
    vo_max = 0;
    for (int f = 0; f < 3; f++) begin
      fill_rand();
      send_frame(0);
    end
    idle(110);
    chk_int("b2b_run", vo_max, 96);

    // Gapped ramp
    fill_ramp();
    send_frame(1);
    wait_first("gap");
    chk_int("gap_latency", seen_edge - done_edge, 1);
    check_ramp_out("gap");
    idle(10);

    // Reset after 10 words of a partial frame
    fill_rand();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid_in = 1'b1;
      drive_word(c);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill_ramp();
    send_frame(0);
    idle(1);
    wait_first("rstmid");
    check_ramp_out("rstmid");
    idle(10);

`ifdef FFT_REORDER_PEAK_EN
    fill_zero();
    fr_re[77] = -2000;
    fr_im[77] = 1000;
    fr_re[400] = -2000;
    fr_im[400] = 1000;
    send_frame(0);
    idle(1);
    begin
      int n;
      n = 0;
      while (!peak_valid && n < 200) begin
        @(posedge clk);
        #2;
        n++;
      end
      chk_int("peak_pulse_seen", int'(peak_valid), 1);
      chk_int("peak_tie_idx", int'(peak_idx), 77);
    end
    idle(10);
`endif

    // Random frames with random gaps
    for (int f = 0; f < 2; f++) begin
      fill_rand();
      send_frame(2);
    end
    idle(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
